mdr_mem_ctrl: RTL and testbench

Memory-transaction sequencer for the CPU's MDR/memory datapath. On a one-cycle request from the control unit it drives the memory strobes, waits on the memory ready handshake with a timeout, and sequences the MDR's mux select and load enable. It sits between the control unit, the MDR (MDMux plus register) and the RAM, and also arbitrates direct bus loads of the MDR against memory transactions.

---
 rtl/mdr_mem_ctrl.sv | 113 +++++++++++
 tb/tb_mdr_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl: sequences one memory read or write per request, with a ready
// handshake and timeout, and drives the MDR mux select and load enable.
module mdr_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic              ld_bus,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mdr_q,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mdr_read,
  output logic              mdr_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state   | meaning
  // IDLE    | accepts req_rd > req_wr > ld_bus; ld_bus loads MDR from the bus
  // RD_WAIT | mem_rd high, MDR loads from memory on the mem_ready edge
  // WR_WAIT | mem_wr high until mem_ready
  // DONE    | one-cycle completion pulse
  // ERR     | one-cycle timeout pulse (done and err), MDR untouched

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  logic             in_wait;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign in_wait     = (state == RD_WAIT) || (state == WR_WAIT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_rd)      state_nxt = RD_WAIT;
        else if (req_wr) state_nxt = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ready)        state_nxt = DONE;
        else if (timeout_hit) state_nxt = ERR;
      end
      DONE, ERR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Address/data are captured only at accept so they stay stable while busy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (req_rd || req_wr) begin
        mem_addr <= addr;
        cnt      <= '0;
      end
      if (!req_rd && req_wr) mem_wdata <= mdr_q;
    end else if (in_wait && !mem_ready && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mdr_read = 1'b0;
    mdr_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        // clr gating keeps the bus load quiet while reset is held
        mdr_en = ld_bus && !req_rd && !req_wr && !clr;
      end
      RD_WAIT: begin
        mem_rd   = 1'b1;
        mdr_read = 1'b1;
        mdr_en   = mem_ready;
      end
      WR_WAIT: mem_wr = 1'b1;
      DONE:    done = 1'b1;
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Bench for mdr_mem_ctrl: transaction-level model checked every cycle, plus
// directed transactions with hand-computed latencies, strobe counts and data.
module tb_mdr_mem_ctrl;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;
  localparam int WINDOW  = 20;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              req_rd = 1'b0, req_wr = 1'b0, ld_bus = 1'b0, mem_ready = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] mdr_q = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd, mem_wr, mdr_read, mdr_en, busy, done, err;

  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] bus_data  = '0;
  logic [DATA_W-1:0] mdr       = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mdr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .req_rd(req_rd), .req_wr(req_wr), .ld_bus(ld_bus),
    .addr(addr), .mdr_q(mdr_q), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mdr_read(mdr_read), .mdr_en(mdr_en), .busy(busy), .done(done), .err(err)
  );

  // The MDR itself: MDMux plus register.
  always @(posedge clk) if (mdr_en) mdr <= mdr_read ? mem_rdata : bus_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: which access is outstanding, how long it has waited,
  // and whether this cycle is the completion or the timeout cycle.
  int                m_kind  = 0;  // 0 none, 1 read, 2 write
  int                m_waits = 0;
  int                m_end   = 0;  // 0 none, 1 completed, 2 timed out
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_wdata = '0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_kind = 0; m_waits = 0; m_end = 0; m_addr = '0; m_wdata = '0;
    end else if (m_end != 0) begin
      m_end = 0;
    end else if (m_kind != 0) begin
      if (mem_ready) begin
        m_end = 1; m_kind = 0;
      end else if (m_waits + 1 == TIMEOUT) begin
        m_end = 2; m_kind = 0;
      end else begin
        m_waits++;
      end
    end else if (req_rd) begin
      m_kind = 1; m_waits = 0; m_addr = addr;
    end else if (req_wr) begin
      m_kind = 2; m_waits = 0; m_addr = addr; m_wdata = mdr_q;
    end
  end

  always @(negedge clk) begin
    logic idle;
    if (chk_en) begin
      idle = (m_kind == 0) && (m_end == 0);
      chk("busy",      busy,      !idle);
      chk("mem_rd",    mem_rd,    m_kind == 1);
      chk("mem_wr",    mem_wr,    m_kind == 2);
      chk("done",      done,      m_end != 0);
      chk("err",       err,       m_end == 2);
      chk("mdr_read",  mdr_read,  m_kind == 1);
      chk("mdr_en",    mdr_en,    (m_kind == 1 && mem_ready) ||
                                  (idle && !clr && ld_bus && !req_rd && !req_wr));
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Issues one request and observes a fixed window after the accept edge.
  // waits < 0 means mem_ready never arrives.
  task automatic do_txn(input bit rd, input bit wr, input bit ld,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int waits, input bit disturb,
                        output int lat, output int rdc, output int wrc,
                        output int dones, output int errs);
    @(posedge clk); #1;
    addr = a; mdr_q = d; req_rd = rd; req_wr = wr; ld_bus = ld;
    @(posedge clk); #1;
    req_rd = 0; req_wr = 0; ld_bus = 0;
    mem_ready = (waits == 0);
    lat = 0; rdc = 0; wrc = 0; dones = 0; errs = 0;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge clk);
      if (mem_rd) rdc++;
      if (mem_wr) wrc++;
      if (done) begin
        if (lat == 0) lat = c;
        dones++;
      end
      if (err) errs++;
      @(posedge clk); #1;
      mem_ready = (waits >= 0) && (c == waits);
      if (disturb && c == 1) begin
        addr = ~a; req_wr = 1;
      end
      if (disturb && c == 2) req_wr = 0;
    end
    mem_ready = 0;
  endtask

  initial begin
    int lat, rdc, wrc, dones, errs;
    logic [DATA_W-1:0] mdr_save;

    #1 clr = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 clr = 0;

    // zero-wait read
    mem_rdata = 32'hDEADBEEF;
    do_txn(1, 0, 0, 9'h05A, 32'h0, 0, 0, lat, rdc, wrc, dones, errs);
    chk("rd0_latency", lat, 2);
    chk("rd0_rd_cycles", rdc, 1);
    chk("rd0_wr_cycles", wrc, 0);
    chk("rd0_dones", dones, 1);
    chk("rd0_errs", errs, 0);
    chk("rd0_mdr", mdr, 32'hDEADBEEF);
    chk("rd0_mem_addr", mem_addr, 9'h05A);

    // write with three wait states
    do_txn(0, 1, 0, 9'h1FF, 32'h12345678, 3, 0, lat, rdc, wrc, dones, errs);
    chk("wr3_latency", lat, 5);
    chk("wr3_wr_cycles", wrc, 4);
    chk("wr3_rd_cycles", rdc, 0);
    chk("wr3_dones", dones, 1);
    chk("wr3_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr3_mem_addr", mem_addr, 9'h1FF);

    // all three requests together: the read wins
    mem_rdata = 32'h0BADF00D;
    bus_data  = 32'h77777777;
    do_txn(1, 1, 1, 9'h0C3, 32'hFFFF0000, 1, 0, lat, rdc, wrc, dones, errs);
    chk("arb_latency", lat, 3);
    chk("arb_rd_cycles", rdc, 2);
    chk("arb_wr_cycles", wrc, 0);
    chk("arb_mdr", mdr, 32'h0BADF00D);
    chk("arb_mem_wdata", mem_wdata, 32'h12345678);

    // bus load alone
    @(posedge clk); #1;
    bus_data = 32'hCAFE0001; ld_bus = 1;
    #1;
    chk("ld_mdr_en", mdr_en, 1);
    chk("ld_mdr_read", mdr_read, 0);
    chk("ld_busy", busy, 0);
    @(posedge clk); #1;
    ld_bus = 0;
    chk("ld_mdr", mdr, 32'hCAFE0001);
    chk("ld_busy_after", busy, 0);

    // timeout: no ready at all
    mem_rdata = 32'hBAD0BAD0;
    do_txn(1, 0, 0, 9'h100, 32'h0, -1, 0, lat, rdc, wrc, dones, errs);
    chk("to_latency", lat, TIMEOUT + 1);
    chk("to_rd_cycles", rdc, TIMEOUT);
    chk("to_dones", dones, 1);
    chk("to_errs", errs, 1);
    chk("to_mdr_kept", mdr, 32'hCAFE0001);

    // addr change and write request while a read is outstanding
    mem_rdata = 32'h31415926;
    do_txn(1, 0, 0, 9'h033, 32'h0, 2, 1, lat, rdc, wrc, dones, errs);
    chk("ign_latency", lat, 4);
    chk("ign_wr_cycles", wrc, 0);
    chk("ign_dones", dones, 1);
    chk("ign_mem_addr", mem_addr, 9'h033);
    chk("ign_mdr", mdr, 32'h31415926);

    // reset in the middle of a read
    @(posedge clk); #1;
    addr = 9'h0AA; req_rd = 1;
    @(posedge clk); #1;
    req_rd = 0; mem_ready = 0;
    @(posedge clk); #1;
    chk("mid_mem_rd", mem_rd, 1);
    mdr_save = mdr;
    mem_rdata = 32'hEEEE0000;
    clr = 1;
    mem_ready = 1;
    #1;
    chk("clr_mem_rd", mem_rd, 0);
    chk("clr_mem_wr", mem_wr, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_err", err, 0);
    chk("clr_mdr_en", mdr_en, 0);
    chk("clr_mdr_read", mdr_read, 0);
    chk("clr_mem_addr", mem_addr, 0);
    chk("clr_mem_wdata", mem_wdata, 0);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("clr_no_done", dones, 0);
    @(posedge clk); #1;
    clr = 0; mem_ready = 0;
    chk("clr_mdr_kept", mdr, mdr_save);

    mem_rdata = 32'h5A5A1234;
    do_txn(1, 0, 0, 9'h101, 32'h0, 0, 0, lat, rdc, wrc, dones, errs);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_mdr", mdr, 32'h5A5A1234);
    chk("post_rst_mem_addr", mem_addr, 9'h101);

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
